// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for RV M-extension DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_TERM_EN skips the dividend's leading zeros before iterating.
`default_nettype none

module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            DivStartE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  output logic            DivBusyE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] ResultE
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY    = 3'd1,
    S_FIXUP   = 3'd2,
    S_SPECIAL = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            rem_sel_q, rem_sel_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, overflow;
  logic [XLEN:0]   r_shift;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN-1:0] q_fix, rem_fix;
  logic            w_unused;

`ifdef DIV_EARLY_TERM_EN
  function automatic int lzc(input logic [XLEN-1:0] v);
    int n;
    n = XLEN;
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) n = XLEN - 1 - i;
    end
    return n;
  endfunction

  int lz;
  assign lz = lzc(abs_a);
`endif

  assign is_signed = ~Funct3E[0];
  assign sign_a    = is_signed & ForwardedSrcAE[XLEN-1];
  assign sign_b    = is_signed & ForwardedSrcBE[XLEN-1];
  assign abs_a     = sign_a ? (~ForwardedSrcAE + 1'b1) : ForwardedSrcAE;
  assign abs_b     = sign_b ? (~ForwardedSrcBE + 1'b1) : ForwardedSrcBE;
  assign div_zero  = (ForwardedSrcBE == '0);
  assign overflow  = is_signed && (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}})
                     && (ForwardedSrcBE == '1);

  // Carry out of the widened subtractor is the R' >= |B| decision.
  assign r_shift = {r_q[XLEN-1:0], a_q[XLEN-1]};
  assign diff    = {1'b0, r_shift} - {2'b00, b_q};
  assign ge      = ~diff[XLEN+1];

  assign q_fix   = negq_q ? (~q_q + 1'b1) : q_q;
  assign rem_fix = negr_q ? (~r_q[XLEN-1:0] + 1'b1) : r_q[XLEN-1:0];

  assign w_unused = Funct3E[2] ^ r_q[XLEN];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    rem_sel_d = rem_sel_q;
    dz_d      = dz_q;
    result_d  = result_q;

    if (FlushE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DivStartE) begin
            rem_sel_d = Funct3E[1];
            negq_d    = sign_a ^ sign_b;
            negr_d    = sign_a;
            b_d       = abs_b;
            r_d       = '0;
            q_d       = '0;
            cnt_d     = CNT_INIT;
            dz_d      = div_zero;
            if (div_zero || overflow) begin
              // Special cases need the raw dividend, not its magnitude.
              a_d     = ForwardedSrcAE;
              state_d = S_SPECIAL;
            end else begin
`ifdef DIV_EARLY_TERM_EN
              if (abs_a == '0) begin
                a_d     = '0;
                state_d = S_FIXUP;
              end else begin
                a_d     = abs_a << lz;
                cnt_d   = CW'(XLEN - 1 - lz);
                state_d = S_BUSY;
              end
`else
              a_d     = abs_a;
              state_d = S_BUSY;
`endif
            end
          end
        end
        S_BUSY: begin
          r_d = ge ? diff[XLEN:0] : r_shift;
          q_d = {q_q[XLEN-2:0], ge};
          a_d = a_q << 1;
          if (cnt_q == '0) state_d = S_FIXUP;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_FIXUP: begin
          result_d = rem_sel_q ? rem_fix : q_fix;
          state_d  = S_DONE;
        end
        S_SPECIAL: begin
          if (dz_q) result_d = rem_sel_q ? a_q : '1;
          else      result_d = rem_sel_q ? '0  : a_q;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (!StallM) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      rem_sel_q <= rem_sel_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
    end
  end

  assign DivBusyE = (state_q == S_BUSY) || (state_q == S_FIXUP) || (state_q == S_SPECIAL)
                    || ((state_q == S_IDLE) && DivStartE && !FlushE);
  assign DivDoneE = (state_q == S_DONE);
  assign ResultE  = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter (XLEN=32) with a reference divide model.
`default_nettype none

module tb_div_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallM = 1'b0;
  logic        FlushE = 1'b0;
  logic        DivStartE = 1'b0;
  logic [31:0] ForwardedSrcAE = '0;
  logic [31:0] ForwardedSrcBE = '0;
  logic [2:0]  Funct3E = 3'b100;
  logic        DivBusyE, DivDoneE;
  logic [31:0] ResultE;

  int n_total = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  div_iter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushE(FlushE),
    .DivStartE(DivStartE), .ForwardedSrcAE(ForwardedSrcAE),
    .ForwardedSrcBE(ForwardedSrcBE), .Funct3E(Funct3E),
    .DivBusyE(DivBusyE), .DivDoneE(DivDoneE), .ResultE(ResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (!f3[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f3);
    logic [31:0] m;
    int lz;
    if (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    m = (!f3[0] && a[31]) ? -a : a;
    lz = 32;
    for (int i = 31; i >= 0; i--) if (m[i] && lz == 32) lz = 31 - i;
`ifdef DIV_EARLY_TERM_EN
    if (m == 32'd0) return 2;
    return 32 - lz + 2;
`else
    return (lz >= 0) ? 34 : 0;
`endif
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input bit stall);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    ForwardedSrcAE = a; ForwardedSrcBE = b; Funct3E = f3;
    DivStartE = 1'b1; StallM = stall;
    exp_q.push_back(model_res(a, b, f3));
    lat_q.push_back(model_lat(a, b, f3));
    #1 check("busy_start", 64'(DivBusyE), 64'd1);
    @(negedge clk);
    DivStartE = 1'b0;
    ForwardedSrcAE = $urandom; ForwardedSrcBE = $urandom;
    Funct3E = 3'(4 + $urandom_range(0, 3));
    lat = 1;
    check("busy_run", 64'(DivBusyE), 64'd1);
    while (!DivDoneE && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    if (!DivDoneE) begin
      check("timeout", 64'd0, 64'd1);
      void'(lat_q.pop_front());
    end else begin
      check("latency", 64'(lat), 64'(lat_q.pop_front()));
      check("result", 64'(ResultE), 64'(e));
      check("busy_done", 64'(DivBusyE), 64'd0);
    end
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        DivStartE = 1'b1;
        ForwardedSrcAE = $urandom; ForwardedSrcBE = $urandom;
        @(negedge clk);
        check("stall_done", 64'(DivDoneE), 64'd1);
        check("stall_res", 64'(ResultE), 64'(e));
      end
      DivStartE = 1'b0;
      StallM = 1'b0;
    end
    @(negedge clk);
    check("done_drop", 64'(DivDoneE), 64'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(DivBusyE), 64'd0);
    check("rst_done", 64'(DivDoneE), 64'd0);
    check("rst_res", 64'(ResultE), 64'd0);

    run_op(32'd100, 32'd7, 3'b101, 1'b0);
    run_op(32'd100, 32'd7, 3'b111, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 3'b100, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 3'b110, 1'b0);
    run_op(32'd5, 32'd0, 3'b100, 1'b0);
    run_op(32'd5, 32'd0, 3'b111, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 1'b0);
    run_op(32'd6, 32'd3, 3'b101, 1'b0);
    run_op(32'd0, 32'd5, 3'b100, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 3'b110, 1'b0);

    // Flush in the middle of an iteration run
    @(negedge clk);
    ForwardedSrcAE = 32'd1000; ForwardedSrcBE = 32'd3; Funct3E = 3'b101;
    DivStartE = 1'b1;
    @(negedge clk);
    DivStartE = 1'b0;
    repeat (9) @(negedge clk);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    check("flush_idle", 64'(DivBusyE), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (DivDoneE) seen = 1;
    end
    check("flush_nodone", 64'(seen), 64'd0);
    run_op(32'd9, 32'd3, 3'b101, 1'b0);

    // Flush wins over a simultaneous start
    @(negedge clk);
    ForwardedSrcAE = 32'd50; ForwardedSrcBE = 32'd5; DivStartE = 1'b1; FlushE = 1'b1;
    @(negedge clk);
    DivStartE = 1'b0; FlushE = 1'b0;
    check("flush_prio", 64'(DivBusyE), 64'd0);

    // Stalled DONE holds the result and ignores further starts
    run_op(32'd1000, 32'd3, 3'b101, 1'b1);
    run_op(32'd5, 32'd0, 3'b111, 1'b1);

    // Reset in mid-division
    @(negedge clk);
    ForwardedSrcAE = 32'd1000; ForwardedSrcBE = 32'd3; Funct3E = 3'b101;
    DivStartE = 1'b1;
    @(negedge clk);
    DivStartE = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", 64'(DivBusyE), 64'd0);
    check("mrst_res", 64'(ResultE), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (DivDoneE) seen = 1;
    end
    check("mrst_nodone", 64'(seen), 64'd0);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_op(ra, rb, 3'(4 + $urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
